// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor pattern history table:
// 2-bit counter encoding, saturating update helper and controller FSM states.
package bp_pkg;

  localparam int CTR_W = 2;
  typedef logic [CTR_W-1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'd0;
  localparam ctr_t CTR_WNT = 2'd1;
  localparam ctr_t CTR_WT  = 2'd2;
  localparam ctr_t CTR_ST  = 2'd3;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  function automatic ctr_t ctr_sat_update(ctr_t ctr, bit taken);
    if (taken) begin
      return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    end
    return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bp_pend_fifo.sv
// Pending-prediction FIFO: head visible combinationally, push/pop take effect at the next edge.
// Flush empties it in one cycle and wins over a same-cycle push; push when full / pop when empty are ignored.
module bp_pend_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CNT_MAX);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
      else if (do_pop && !do_push) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/bp_table_ctrl.sv
// Pattern history table controller: 1-cycle prediction latency, in-order resolves update the counter each prediction used.
// Requests are back-pressured (req_ready low) while sweeping after reset or when Q_DEPTH predictions are outstanding.
module bp_table_ctrl
  import bp_pkg::*;
#(
  parameter int   IDX_W    = 4,
  parameter int   Q_DEPTH  = 4,
  parameter ctr_t CTR_INIT = 2'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [IDX_W-1:0] req_idx,
  output logic             req_ready,
  output logic             pred_valid,
  output logic             pred_taken,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  input  logic             flush,
  output logic             mispredict,
  output logic             resolve_err,
  output logic             busy
);

  localparam int QW = $clog2(Q_DEPTH);
  localparam int ENTRIES = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] PTR_ONE  = 1;
  localparam logic [IDX_W-1:0] PTR_LAST = '1;
  localparam logic [QW:0]      Q_FULL   = (QW+1)'(Q_DEPTH);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             pred;
  } pend_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] init_ptr_q, init_ptr_d;
  ctr_t             tbl_q [ENTRIES];

  logic  pred_valid_q, pred_valid_d;
  logic  pred_taken_q, pred_taken_d;
  logic  mispredict_q, mispredict_d;
  logic  resolve_err_q, resolve_err_d;

  logic        run;
  logic        req_acc, res_acc, bypass;
  ctr_t        upd_ctr, rd_ctr;
  pend_t       push_dat, head_dat;
  logic        fifo_push, fifo_full, fifo_empty;
  logic [QW:0] fifo_count;

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    busy       = 1'b0;
    run        = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        busy       = 1'b1;
        init_ptr_d = init_ptr_q + PTR_ONE;
        if (init_ptr_q == PTR_LAST) state_d = ST_RUN;
      end
      ST_RUN:  run = 1'b1;
      default: state_d = ST_INIT;
    endcase
  end

  assign req_ready = run && (fifo_count != Q_FULL);
  // A flush drops the same-cycle request, but a same-cycle resolve still pops and updates.
  assign req_acc   = req_valid && req_ready && !flush;
  assign res_acc   = run && resolve_valid && !fifo_empty;

  assign upd_ctr = ctr_sat_update(tbl_q[head_dat.idx], resolve_taken);
  assign bypass  = res_acc && (head_dat.idx == req_idx);
  assign rd_ctr  = bypass ? upd_ctr : tbl_q[req_idx];

  assign push_dat.idx  = req_idx;
  assign push_dat.pred = rd_ctr[CTR_W-1];
  assign fifo_push     = req_acc && !fifo_full;

  always_comb begin
    pred_valid_d  = req_acc;
    pred_taken_d  = req_acc && rd_ctr[CTR_W-1];
    mispredict_d  = res_acc && (head_dat.pred != resolve_taken);
    resolve_err_d = run && resolve_valid && fifo_empty;
  end

  bp_pend_fifo #(
    .W     ($bits(pend_t)),
    .DEPTH (Q_DEPTH)
  ) u_pend_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (res_acc),
    .flush_i (run && flush),
    .wdata_i (push_dat),
    .rdata_o (head_dat),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Counter storage has no reset; the sweep in ST_INIT defines every entry.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) tbl_q[init_ptr_q] <= CTR_INIT;
    else if (res_acc)       tbl_q[head_dat.idx] <= upd_ctr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_INIT;
      init_ptr_q    <= '0;
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      mispredict_q  <= 1'b0;
      resolve_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_ptr_q    <= init_ptr_d;
      pred_valid_q  <= pred_valid_d;
      pred_taken_q  <= pred_taken_d;
      mispredict_q  <= mispredict_d;
      resolve_err_q <= resolve_err_d;
    end
  end

  assign pred_valid  = pred_valid_q;
  assign pred_taken  = pred_taken_q;
  assign mispredict  = mispredict_q;
  assign resolve_err = resolve_err_q;

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Directed bench for bp_table_ctrl: hand-computed counter trajectories, queue fill, bypass, flush and reset cases.
module tb_bp_table_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [3:0] req_idx;
  logic       req_ready;
  logic       pred_valid;
  logic       pred_taken;
  logic       resolve_valid;
  logic       resolve_taken;
  logic       flush;
  logic       mispredict;
  logic       resolve_err;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;

  bp_table_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_idx       (req_idx),
    .req_ready     (req_ready),
    .pred_valid    (pred_valid),
    .pred_taken    (pred_taken),
    .resolve_valid (resolve_valid),
    .resolve_taken (resolve_taken),
    .flush         (flush),
    .mispredict    (mispredict),
    .resolve_err   (resolve_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sweep(input string tag);
    int   cyc = 0;
    logic rdy_seen = 1'b0;
    while (busy && cyc < 100) begin
      if (req_ready) rdy_seen = 1'b1;
      tick();
      cyc++;
    end
    check({tag, "_cycles"}, 32'(cyc), 32'd16);
    check({tag, "_rdy_in_init"}, 32'(rdy_seen), 32'd0);
  endtask

  task automatic predict(input string tag, input logic [3:0] idx, input logic exp);
    req_valid = 1'b1;
    req_idx   = idx;
    check({tag, "_rdy"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check(tag, 32'({pred_valid, pred_taken}), 32'({1'b1, exp}));
  endtask

  task automatic resolve(input string tag, input logic taken, input logic exp_mis);
    resolve_valid = 1'b1;
    resolve_taken = taken;
    tick();
    resolve_valid = 1'b0;
    check(tag, 32'({mispredict, resolve_err}), 32'({exp_mis, 1'b0}));
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic err_seen;
    rst = 1'b1;
    req_valid = 1'b0;
    req_idx = '0;
    resolve_valid = 1'b0;
    resolve_taken = 1'b0;
    flush = 1'b0;
    #1;
    check("rst_outs", 32'({pred_valid, pred_taken, mispredict, resolve_err, req_ready}), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    tick();
    tick();
    rst = 1'b0;

    // 1: sweep length, then every entry weakly not-taken
    wait_sweep("sweep0");
    for (int i = 0; i < 16; i++) begin
      predict($sformatf("init_idx%0d", i), 4'(i), 1'b0);
      do_flush();
    end

    // 2: idx 5 climbs 1->2->3->3->3, then falls 3->2->1
    predict("t2_p0", 4'd5, 1'b0); resolve("t2_r0", 1'b1, 1'b1);
    predict("t2_p1", 4'd5, 1'b1); resolve("t2_r1", 1'b1, 1'b0);
    predict("t2_p2", 4'd5, 1'b1); resolve("t2_r2", 1'b1, 1'b0);
    predict("t2_p3", 4'd5, 1'b1); resolve("t2_r3", 1'b1, 1'b0);
    predict("t2_p4", 4'd5, 1'b1); resolve("t2_r4", 1'b0, 1'b1);
    predict("t2_p5", 4'd5, 1'b1); resolve("t2_r5", 1'b0, 1'b1);
    predict("t2_p6", 4'd5, 1'b0);
    do_flush();

    // 3: fill the queue, then concurrent resolve+request keeps occupancy
    req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_idx = 4'(k);
      check($sformatf("fill_rdy%0d", k), 32'(req_ready), 32'd1);
      tick();
      check($sformatf("fill_pred%0d", k), 32'({pred_valid, pred_taken}), 32'b10);
    end
    check("full_rdy", 32'(req_ready), 32'd0);
    req_idx = 4'd4;
    tick();
    req_valid = 1'b0;
    check("full_drop", 32'(pred_valid), 32'd0);
    resolve("full_res", 1'b0, 1'b0);
    check("after_pop_rdy", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_idx = 4'd8;
    resolve_valid = 1'b1; resolve_taken = 1'b0;
    tick();
    req_valid = 1'b0; resolve_valid = 1'b0;
    check("both_acc", 32'({pred_valid, pred_taken, mispredict}), 32'b100);
    check("both_rdy", 32'(req_ready), 32'd1);
    predict("refill", 4'd9, 1'b0);
    check("refill_rdy", 32'(req_ready), 32'd0);
    do_flush();

    // 4: same-cycle resolve taken on idx 7 bypasses into a new prediction
    predict("byp_p0", 4'd7, 1'b0);
    req_valid = 1'b1; req_idx = 4'd7;
    resolve_valid = 1'b1; resolve_taken = 1'b1;
    tick();
    req_valid = 1'b0; resolve_valid = 1'b0;
    check("bypass", 32'({pred_valid, pred_taken, mispredict}), 32'b111);
    do_flush();

    // 5: flush with concurrent resolve and request
    predict("fl_p10", 4'd10, 1'b0);
    predict("fl_p11", 4'd11, 1'b0);
    req_valid = 1'b1; req_idx = 4'd12;
    tick();
    flush = 1'b1; resolve_valid = 1'b1; resolve_taken = 1'b1; req_idx = 4'd13;
    check("fl_prior_pred", 32'({pred_valid, pred_taken}), 32'b10);
    tick();
    flush = 1'b0; resolve_valid = 1'b0; req_valid = 1'b0;
    check("fl_outs", 32'({pred_valid, mispredict, resolve_err}), 32'b010);
    check("fl_rdy", 32'(req_ready), 32'd1);
    resolve_valid = 1'b1; resolve_taken = 1'b1;
    tick();
    resolve_valid = 1'b0;
    check("fl_err", 32'({mispredict, resolve_err}), 32'b01);
    predict("fl_upd10", 4'd10, 1'b1);
    do_flush();
    predict("fl_keep11", 4'd11, 1'b0);
    do_flush();

    // 6: reset mid-RUN then mid-sweep
    predict("r_p14", 4'd14, 1'b0);
    req_valid = 1'b1; req_idx = 4'd15;
    resolve_valid = 1'b1; resolve_taken = 1'b1;
    tick();
    req_valid = 1'b0; resolve_valid = 1'b0;
    check("r_pre", 32'({pred_valid, mispredict}), 32'b11);
    #2;
    rst = 1'b1;
    #1;
    check("r_run_outs", 32'({pred_valid, pred_taken, mispredict, resolve_err, req_ready}), 32'd0);
    check("r_run_busy", 32'(busy), 32'd1);
    tick();
    rst = 1'b0;
    resolve_valid = 1'b1; flush = 1'b1;
    err_seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (resolve_err || !busy) err_seen = 1'b1;
    end
    check("init_ignore", 32'(err_seen), 32'd0);
    resolve_valid = 1'b0; flush = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("r_sweep_busy", 32'({busy, req_ready}), 32'b10);
    tick();
    rst = 1'b0;
    wait_sweep("sweep1");
    predict("r_resweep14", 4'd14, 1'b0);
    resolve("r_res14", 1'b1, 1'b1);
    resolve_valid = 1'b1; resolve_taken = 1'b0;
    tick();
    resolve_valid = 1'b0;
    check("r_empty_err", 32'({mispredict, resolve_err}), 32'b01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
